// File: rtl/mmio_pkg.sv
// -----------------------------------------------------------------------------
// mmio_pkg
// Shared constants for the memory-mapped timer/UART responder:
//   - register offsets inside the 256-byte window
//   - funct3-style access size encodings
//   - STATUS register bit positions
//   - load formatting helper (lane select plus sign/zero extension)
// -----------------------------------------------------------------------------
package mmio_pkg;

  // Register offsets (a[7:0])
  localparam logic [7:0] OFF_TXDATA      = 8'h00;
  localparam logic [7:0] OFF_STATUS      = 8'h04;
  localparam logic [7:0] OFF_MTIME_LO    = 8'h08;
  localparam logic [7:0] OFF_MTIME_HI    = 8'h0C;
  localparam logic [7:0] OFF_MTIMECMP_LO = 8'h10;
  localparam logic [7:0] OFF_MTIMECMP_HI = 8'h14;

  // Access sizes (funct3 encoding)
  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  // STATUS bit positions
  localparam int ST_TX_EMPTY  = 0;
  localparam int ST_TX_FULL   = 1;
  localparam int ST_TIMER_IRQ = 2;
  localparam int ST_OVERFLOW  = 3;
  localparam int ST_COUNT_LSB = 8;

  // Picks the addressed byte/half out of a register word and extends it the
  // way the load instruction expects; unknown size codes return the word.
  function automatic logic [31:0] fmt_load(input logic [31:0] word,
                                           input logic [2:0]  size,
                                           input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    res = {{24{b[7]}}, b};
      SZ_H:    res = {{16{h[15]}}, h};
      SZ_BU:   res = {24'h00_0000, b};
      SZ_HU:   res = {16'h0000, h};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered storage; head entry is visible on o_head
// whenever the FIFO is non-empty. Storage is cleared by reset so the head
// reads zero afterwards.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   i_push       write i_data (accepted when not full, or when popping too)
//   i_data       entry to write
//   i_pop        consume the head entry (ignored when empty)
//   o_head       entry at the read pointer
//   o_empty      no entries
//   o_full       DEPTH entries
//   o_count      number of entries, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1'b1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rptr;
  logic [AW-1:0]    r_wptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == {(AW+1){1'b0}});
  assign o_full    = (r_count == CNT_FULL);
  assign w_do_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_head    = r_mem[r_rptr];
  assign o_count   = r_count;

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
      r_rptr  <= {AW{1'b0}};
      r_wptr  <= {AW{1'b0}};
      r_count <= {(AW+1){1'b0}};
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_timer_uart.sv
// -----------------------------------------------------------------------------
// mmio_timer_uart
// Peripheral responder on the data-memory bus: 64-bit machine timer with a
// compare interrupt plus a byte TX FIFO drained over a valid/ready stream.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   we, mem_size, a, wd store strobe, funct3 size, byte address, store data
//   hit                 address falls in this 256-byte window
//   rd                  formatted load data, zero outside the window
//   tx_byte, tx_valid   FIFO head and non-empty flag
//   tx_ready            downstream accepts tx_byte this cycle
//   timer_irq           mtime >= mtimecmp (unsigned, from registered values)
// -----------------------------------------------------------------------------
module mmio_timer_uart
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE       = 32'h0002_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [2:0]  mem_size,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic        hit,
  output logic [31:0] rd,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        timer_irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          w_hit;
  logic [7:0]    w_off;
  logic [7:0]    w_word_off;
  logic          w_wr;
  logic          w_wr_word;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic          w_full;
  logic          w_irq;
  logic [CW-1:0] w_count;
  logic [31:0]   w_rd_word;
  logic [63:0]   r_mtime;
  logic [63:0]   r_mtimecmp;
  logic          r_overflow;

  assign w_hit      = (a[31:8] == BASE[31:8]);
  assign w_off      = a[7:0];
  // Loads address any byte of a register; the word offset picks the register.
  assign w_word_off = {a[7:2], 2'b00};
  assign w_wr       = we && w_hit;
  assign w_wr_word  = w_wr && (mem_size == SZ_W);
  assign w_push     = w_wr && (w_off == OFF_TXDATA);
  assign w_pop      = !w_empty && tx_ready;
  assign w_irq      = (r_mtime >= r_mtimecmp);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (wd[7:0]),
    .i_pop   (tx_ready),
    .o_head  (tx_byte),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_count)
  );

  // Machine timer: a store to either half replaces that half and skips the
  // increment for that cycle, so no carry crosses halves on a store.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mtime <= 64'd0;
    end else if (w_wr_word && (w_off == OFF_MTIME_LO)) begin
      r_mtime[31:0] <= wd;
    end else if (w_wr_word && (w_off == OFF_MTIME_HI)) begin
      r_mtime[63:32] <= wd;
    end else begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  // Compare register, changed by word stores only.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
    end else if (w_wr_word && (w_off == OFF_MTIMECMP_LO)) begin
      r_mtimecmp[31:0] <= wd;
    end else if (w_wr_word && (w_off == OFF_MTIMECMP_HI)) begin
      r_mtimecmp[63:32] <= wd;
    end else begin
      r_mtimecmp <= r_mtimecmp;
    end
  end

  // Sticky overflow: set when a byte is dropped, cleared by writing 1 to bit 3.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end else if (w_wr_word && (w_off == OFF_STATUS) && wd[ST_OVERFLOW]) begin
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= r_overflow;
    end
  end

  // Register read mux; TXDATA and unmapped offsets read zero.
  always_comb begin
    w_rd_word = 32'd0;
    case (w_word_off)
      OFF_STATUS: begin
        w_rd_word[ST_TX_EMPTY]            = w_empty;
        w_rd_word[ST_TX_FULL]             = w_full;
        w_rd_word[ST_TIMER_IRQ]           = w_irq;
        w_rd_word[ST_OVERFLOW]            = r_overflow;
        w_rd_word[ST_COUNT_LSB +: CW]     = w_count;
      end
      OFF_MTIME_LO:    w_rd_word = r_mtime[31:0];
      OFF_MTIME_HI:    w_rd_word = r_mtime[63:32];
      OFF_MTIMECMP_LO: w_rd_word = r_mtimecmp[31:0];
      OFF_MTIMECMP_HI: w_rd_word = r_mtimecmp[63:32];
      default:         w_rd_word = 32'd0;
    endcase
  end

  assign hit       = w_hit;
  // Zero outside the window so the result can be OR-merged with dmem data.
  assign rd        = w_hit ? fmt_load(w_rd_word, mem_size, a[1:0]) : 32'd0;
  assign tx_valid  = !w_empty;
  assign timer_irq = w_irq;

endmodule

// File: tb/tb_mmio_timer_uart.sv
module tb_mmio_timer_uart;
  import mmio_pkg::*;

  localparam logic [31:0] BASE  = 32'h0002_0000;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset, we, tx_ready;
  logic [2:0]  mem_size;
  logic [31:0] a, wd, rd;
  logic        hit, tx_valid, timer_irq;
  logic [7:0]  tx_byte;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0]  model_q[$];
  logic        model_ovf;
  logic [63:0] model_cmp;

  always #5 clk = ~clk;

  mmio_timer_uart #(.BASE(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .we(we), .mem_size(mem_size), .a(a), .wd(wd),
    .hit(hit), .rd(rd), .tx_byte(tx_byte), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .timer_irq(timer_irq)
  );

  // Reference load formatting from the ISA rules, using shifts and arithmetic.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] sz, input logic [1:0] ofs);
    logic [31:0] v;
    int lane;
    lane = int'(ofs);
    case (sz)
      3'b000: begin v = (w >> (8 * lane)) & 32'hFF; if (v >= 32'd128) v = v + 32'hFFFF_FF00; end
      3'b001: begin v = (w >> (16 * (lane / 2))) & 32'hFFFF; if (v >= 32'd32768) v = v + 32'hFFFF_0000; end
      3'b100: v = (w >> (8 * lane)) & 32'hFF;
      3'b101: v = (w >> (16 * (lane / 2))) & 32'hFFFF;
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = 32'd0;
    s[15:8] = 8'(model_q.size());
    s[3] = model_ovf;
    s[1] = (model_q.size() == DEPTH);
    s[0] = (model_q.size() == 0);
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] sz);
    a = addr; wd = data; mem_size = sz; we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic load(input logic [31:0] addr, input logic [2:0] sz, output logic [31:0] d);
    we = 1'b0; a = addr; mem_size = sz;
    #1;
    d = rd;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1; we = 1'b0; tx_ready = 1'b1;
    repeat (3) tick();
    total_cnt++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); else pass_cnt++;
    total_cnt++; if (tx_byte !== 8'h00) $display("FAIL reset_tx_byte got=%h exp=00", tx_byte); else pass_cnt++;
    tx_ready = 1'b0; reset = 1'b0;
    load(BASE + 32'h04, SZ_W, d);
    total_cnt++; if (d !== 32'h0000_0001) $display("FAIL reset_status got=%h exp=00000001", d); else pass_cnt++;
    total_cnt++; if (timer_irq !== 1'b0) $display("FAIL reset_irq got=%b exp=0", timer_irq); else pass_cnt++;
    load(BASE + 32'h08, SZ_W, d);
    total_cnt++; if (d !== 32'h0) $display("FAIL reset_mtime got=%h exp=0", d); else pass_cnt++;
    model_q.delete(); model_ovf = 1'b0; model_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
  endtask

  task automatic test_tx_basic();
    logic [31:0] d;
    logic [7:0] exp_b [3] = '{8'h41, 8'h42, 8'h43};
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) store(BASE, {24'h0, exp_b[i]}, SZ_B);
    load(BASE + 32'h04, SZ_W, d);
    total_cnt++; if (d !== 32'h0000_0300) $display("FAIL basic_status got=%h exp=00000300", d); else pass_cnt++;
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (tx_valid !== 1'b1 || tx_byte !== exp_b[i]) $display("FAIL basic_drain[%0d] got=%b/%h exp=1/%h", i, tx_valid, tx_byte, exp_b[i]);
      else pass_cnt++;
      tick();
    end
    total_cnt++; if (tx_valid !== 1'b0) $display("FAIL basic_empty got=%b exp=0", tx_valid); else pass_cnt++;
    tx_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic [7:0] exp_b [8] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h19};
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) store(BASE, 32'h10 + i, SZ_B);
    load(BASE + 32'h04, SZ_W, d);
    total_cnt++; if (d !== 32'h0000_080A) $display("FAIL ovf_status got=%h exp=0000080A", d); else pass_cnt++;
    store(BASE + 32'h04, 32'h8, SZ_B);
    load(BASE + 32'h04, SZ_W, d);
    total_cnt++; if (d !== 32'h0000_080A) $display("FAIL ovf_subword_clear got=%h exp=0000080A", d); else pass_cnt++;
    store(BASE + 32'h04, 32'h8, SZ_W);
    load(BASE + 32'h04, SZ_W, d);
    total_cnt++; if (d !== 32'h0000_0802) $display("FAIL ovf_clear got=%h exp=00000802", d); else pass_cnt++;
    tx_ready = 1'b1;
    store(BASE, 32'h19, SZ_B);
    tx_ready = 1'b0;
    load(BASE + 32'h04, SZ_W, d);
    total_cnt++; if (d !== 32'h0000_0802) $display("FAIL full_pushpop_status got=%h exp=00000802", d); else pass_cnt++;
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if (tx_valid !== 1'b1 || tx_byte !== exp_b[i]) $display("FAIL ovf_drain[%0d] got=%b/%h exp=1/%h", i, tx_valid, tx_byte, exp_b[i]);
      else pass_cnt++;
      tick();
    end
    total_cnt++; if (tx_valid !== 1'b0) $display("FAIL ovf_empty got=%b exp=0", tx_valid); else pass_cnt++;
    tx_ready = 1'b0;
  endtask

  task automatic test_fifo_random();
    logic [31:0] d, data, exp_s;
    logic rdy, pop;
    int act, n;
    logic [2:0] szs [3] = '{SZ_B, SZ_H, SZ_W};
    for (int it = 0; it < 200; it++) begin
      act = int'($urandom_range(0, 9));
      rdy = ($urandom_range(0, 2) == 0);
      total_cnt++;
      if (tx_valid !== (model_q.size() != 0)) $display("FAIL rnd_valid[%0d] got=%b exp=%0d", it, tx_valid, model_q.size() != 0);
      else pass_cnt++;
      if (model_q.size() != 0) begin
        total_cnt++;
        if (tx_byte !== model_q[0]) $display("FAIL rnd_byte[%0d] got=%h exp=%h", it, tx_byte, model_q[0]);
        else pass_cnt++;
      end
      tx_ready = rdy;
      pop = rdy && (model_q.size() != 0);
      n = model_q.size();
      if (act < 6) begin
        data = $urandom;
        store(BASE, data, szs[$urandom_range(0, 2)]);
        if (pop) void'(model_q.pop_front());
        if (n == DEPTH && !pop) model_ovf = 1'b1;
        else model_q.push_back(data[7:0]);
      end else if (act < 9) begin
        load(BASE + 32'h04, SZ_W, d);
        exp_s = model_status();
        total_cnt++;
        if (d !== exp_s) $display("FAIL rnd_status[%0d] got=%h exp=%h", it, d, exp_s);
        else pass_cnt++;
        tick();
        if (pop) void'(model_q.pop_front());
      end else begin
        store(BASE + 32'h04, 32'h8, SZ_W);
        if (pop) void'(model_q.pop_front());
        model_ovf = 1'b0;
      end
    end
    tx_ready = 1'b1;
    while (model_q.size() != 0) begin
      total_cnt++;
      if (tx_byte !== model_q[0] || tx_valid !== 1'b1) $display("FAIL rnd_drain got=%b/%h exp=1/%h", tx_valid, tx_byte, model_q[0]);
      else pass_cnt++;
      void'(model_q.pop_front());
      tick();
    end
    tx_ready = 1'b0;
    store(BASE + 32'h04, 32'h8, SZ_W);
    model_ovf = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) store(BASE, $urandom | 32'h1, SZ_B);
    tx_ready = 1'b1; reset = 1'b1;
    tick();
    total_cnt++; if (tx_valid !== 1'b0 || tx_byte !== 8'h00) $display("FAIL midreset_out got=%b/%h exp=0/00", tx_valid, tx_byte); else pass_cnt++;
    tick();
    reset = 1'b0; tx_ready = 1'b0;
    load(BASE + 32'h04, SZ_W, d);
    total_cnt++; if (d !== 32'h0000_0001) $display("FAIL midreset_status got=%h exp=00000001", d); else pass_cnt++;
    load(BASE + 32'h08, SZ_W, d);
    total_cnt++; if (d !== 32'h0) $display("FAIL midreset_mtime got=%h exp=0", d); else pass_cnt++;
    model_q.delete(); model_ovf = 1'b0; model_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
  endtask

  task automatic test_load_format();
    logic [31:0] d, r, e;
    logic [2:0] sizes [6] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b111};
    store(BASE + 32'h08, 32'h0000_80F0, SZ_W);
    load(BASE + 32'h08, SZ_B, d);
    total_cnt++; if (d !== 32'hFFFF_FFF0) $display("FAIL lb_mtime got=%h exp=FFFFFFF0", d); else pass_cnt++;
    load(BASE + 32'h08, SZ_BU, d);
    total_cnt++; if (d !== 32'h0000_00F0) $display("FAIL lbu_mtime got=%h exp=000000F0", d); else pass_cnt++;
    load(BASE + 32'h08, SZ_H, d);
    total_cnt++; if (d !== 32'hFFFF_80F0) $display("FAIL lh_mtime got=%h exp=FFFF80F0", d); else pass_cnt++;
    tick();
    for (int k = 0; k < 4; k++) begin
      r = $urandom;
      store(BASE + 32'h10, r, SZ_W);
      model_cmp[31:0] = r;
      for (int lane = 0; lane < 4; lane++) begin
        for (int s = 0; s < 6; s++) begin
          load(BASE + 32'h10 + lane, sizes[s], d);
          e = ref_load(r, sizes[s], 2'(lane));
          total_cnt++;
          if (d !== e || hit !== 1'b1) $display("FAIL fmt sz=%b lane=%0d got=%h/%b exp=%h/1", sizes[s], lane, d, hit, e);
          else pass_cnt++;
          tick();
        end
      end
    end
    store(BASE + 32'h10, 32'hAA, SZ_B);
    load(BASE + 32'h10, SZ_W, d);
    total_cnt++; if (d !== model_cmp[31:0]) $display("FAIL cmp_subword_ignored got=%h exp=%h", d, model_cmp[31:0]); else pass_cnt++;
  endtask

  task automatic test_miss();
    logic [31:0] d;
    load(BASE + 32'h100, SZ_W, d);
    total_cnt++; if (hit !== 1'b0 || d !== 32'h0) $display("FAIL miss_load got=%b/%h exp=0/0", hit, d); else pass_cnt++;
    store(BASE + 32'h100, 32'h55, SZ_B);
    store(32'h0003_0010, $urandom, SZ_W);
    store(32'h0001_FF14, $urandom, SZ_W);
    store(32'h0012_0004, 32'h0, SZ_W);
    load(BASE + 32'h04, SZ_W, d);
    total_cnt++; if (d !== 32'h0000_0001 || tx_valid !== 1'b0) $display("FAIL miss_status got=%h/%b exp=00000001/0", d, tx_valid); else pass_cnt++;
    tick();
    load(BASE + 32'h10, SZ_W, d);
    total_cnt++; if (d !== model_cmp[31:0]) $display("FAIL miss_cmp_lo got=%h exp=%h", d, model_cmp[31:0]); else pass_cnt++;
    load(BASE + 32'h14, SZ_W, d);
    total_cnt++; if (d !== model_cmp[63:32]) $display("FAIL miss_cmp_hi got=%h exp=%h", d, model_cmp[63:32]); else pass_cnt++;
    tick();
  endtask

  task automatic test_timer_carry();
    logic [31:0] d;
    store(BASE + 32'h08, 32'hFFFF_FFFE, SZ_W);
    store(BASE + 32'h0C, 32'h0, SZ_W);
    repeat (3) tick();
    load(BASE + 32'h0C, SZ_W, d);
    total_cnt++; if (d !== 32'h1) $display("FAIL carry_hi got=%h exp=00000001", d); else pass_cnt++;
    load(BASE + 32'h08, SZ_W, d);
    total_cnt++; if (d !== 32'h1) $display("FAIL carry_lo got=%h exp=00000001", d); else pass_cnt++;
  endtask

  task automatic test_timer_irq();
    logic [31:0] d;
    store(BASE + 32'h14, 32'h0, SZ_W);
    store(BASE + 32'h10, 32'd100, SZ_W);
    model_cmp = 64'd100;
    store(BASE + 32'h0C, 32'h0, SZ_W);
    store(BASE + 32'h08, 32'd95, SZ_W);
    for (int k = 0; k < 10; k++) begin
      load(BASE + 32'h08, SZ_W, d);
      total_cnt++;
      if (d !== 32'(95 + k) || timer_irq !== ((95 + k) >= 100)) $display("FAIL irq_step[%0d] got=%0d/%b exp=%0d/%0d", k, d, timer_irq, 95 + k, (95 + k) >= 100);
      else pass_cnt++;
      tick();
    end
    store(BASE + 32'h14, 32'h1, SZ_W);
    model_cmp[63:32] = 32'h1;
    total_cnt++; if (timer_irq !== 1'b0) $display("FAIL irq_cmp_hi got=%b exp=0", timer_irq); else pass_cnt++;
  endtask

  task automatic test_timer_random();
    logic [31:0] h, l, dlo, dhi;
    logic [63:0] m;
    int n;
    for (int k = 0; k < 6; k++) begin
      h = $urandom; l = $urandom;
      if (k == 0) begin h = 32'hFFFF_FFFF; l = 32'hFFFF_FFFD; end
      if (k == 1) l = 32'hFFFF_FFFF;
      model_cmp = {$urandom, $urandom};
      if (k == 2) model_cmp = {h, l + 32'd2};
      store(BASE + 32'h14, model_cmp[63:32], SZ_W);
      store(BASE + 32'h10, model_cmp[31:0], SZ_W);
      store(BASE + 32'h0C, h, SZ_W);
      store(BASE + 32'h08, l, SZ_W);
      n = (k == 0) ? 5 : int'($urandom_range(0, 5));
      repeat (n) tick();
      m = {h, l} + 64'(n);
      load(BASE + 32'h08, SZ_W, dlo);
      load(BASE + 32'h0C, SZ_W, dhi);
      total_cnt++;
      if ({dhi, dlo} !== m || timer_irq !== (m >= model_cmp)) $display("FAIL timer_rnd[%0d] got=%h/%b exp=%h/%b", k, {dhi, dlo}, timer_irq, m, m >= model_cmp);
      else pass_cnt++;
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; we = 1'b0; a = 32'h0; wd = 32'h0; mem_size = SZ_W; tx_ready = 1'b0;
    model_ovf = 1'b0; model_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
    test_reset();
    test_tx_basic();
    test_overflow();
    test_fifo_random();
    test_reset_mid();
    test_load_format();
    test_miss();
    test_timer_carry();
    test_timer_irq();
    test_timer_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mmio_timer_uart.md
Name: mmio_timer_uart

Overview:
- Memory-mapped peripheral responder on the core's data-memory bus. It sits beside dmem and decodes its own address window.
- Answers the core's load and store accesses: same address, write-enable, size and write-data signals that dmem sees.
- Provides a free-running 64-bit machine timer with a compare interrupt, and a byte TX FIFO drained over a valid/ready byte stream toward a console/UART serializer.

Parameters:
- BASE, 32'h0002_0000, window base address; must be 256-byte aligned.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..64.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- we  in  1  store strobe from core (mem_write, M stage)
- mem_size  in  3  access size; funct3 encoding: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu
- a  in  32  byte address (ALU result, M stage)
- wd  in  32  store data, right-aligned
- hit  out  1  combinational: a[31:8] == BASE[31:8]
- rd  out  32  combinational load data, already aligned and extended; 0 when !hit
- tx_byte  out  8  FIFO head byte
- tx_valid  out  1  FIFO non-empty
- tx_ready  in  1  downstream accepts tx_byte this cycle
- timer_irq  out  1  level: mtime >= mtimecmp, unsigned 64-bit comparison

Behaviour:
- Register map (offset a[7:0]); all other offsets read 0 and ignore writes:
  - 0x00 TXDATA: a store of any size pushes wd[7:0]; reads 0.
  - 0x04 STATUS, read fields: [0] tx_empty, [1] tx_full, [2] timer_irq, [3] overflow (sticky), [15:8] FIFO count. Write: a word store with wd[3]=1 clears overflow; all other bits read-only.
  - 0x08 MTIME_LO, 0x0C MTIME_HI, 0x10 MTIMECMP_LO, 0x14 MTIMECMP_HI: R/W.
- Stores take effect on the rising clk edge when we && hit. Registers other than TXDATA accept word stores only; sub-word stores to them are ignored.
- Loads are combinational from current state, with no wait state, matching dmem timing.
  - Byte lane select: a[1:0] for bytes, a[1] for halves.
  - Sign-extend for 000/001; zero-extend for 100/101.
  - Any other mem_size code returns the full word.
- Timer:
  - mtime increments by 1 every cycle and wraps from 2^64-1 to 0.
  - A store to MTIME_LO/HI loads that half with wd; the increment is suppressed that cycle. There is no carry into the other half that cycle.
  - mtimecmp changes only by store.
  - timer_irq updates the cycle after any mtime/mtimecmp change, because it is compared from registered values.
- TX FIFO:
  - tx_valid = !empty; tx_byte = entry at read pointer.
  - Pop on tx_valid && tx_ready.
  - Push on a TXDATA store.
  - Push while full and no pop: the byte is dropped and overflow is set.
  - Simultaneous push and pop while full: both occur, count stays at FIFO_DEPTH, no overflow.
  - Simultaneous push and pop with count 1..DEPTH-1: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH. Count width is clog2(DEPTH)+1.
- Reset (synchronous, active-high):
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, FIFO empty, overflow=0.
  - Outputs after reset: tx_valid=0, tx_byte=0 (storage cleared), timer_irq=0.
  - Reset asserted mid-transfer discards all FIFO contents; a pending tx_ready is ignored during reset.
- A !hit store never modifies state. A !hit load drives rd=0 so it can be OR-merged with dmem read data.

Decomposition:
- Package mmio_pkg:
  - register offsets (OFF_TXDATA, OFF_STATUS, OFF_MTIME_LO/HI, OFF_MTIMECMP_LO/HI)
  - mem_size encodings (SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU)
  - STATUS bit indices
- One sub-module: sync_fifo (parameterised width/depth). It provides push/pop/full/empty/count and the head output.
- Timer, address decode and load formatting stay in the top of the block.

Test Plan:
- Reset, then read STATUS with lw @BASE+0x04 -> rd=32'h0000_0001; tx_valid=0; timer_irq=0.
- sb 0x41,0x42,0x43 to BASE+0x00 with tx_ready=0 -> STATUS[15:8]=3. Then tx_ready=1 -> tx_byte sequence 0x41,0x42,0x43 over 3 cycles; tx_valid falls after the third.
- 9 pushes with DEPTH=8 and tx_ready=0 -> count=8, tx_full=1, overflow=1, 9th byte absent from drain. Then sw 32'h8 to STATUS -> overflow=0. Push while full with tx_ready=1 -> count stays 8, overflow stays 0.
- sw 32'hFFFF_FFFE to MTIME_LO and 0 to MTIME_HI, then wait 3 cycles -> MTIME_HI reads 1, MTIME_LO reads 1 (carry crosses halves).
- mtimecmp=100 and mtime=95 -> timer_irq rises exactly when mtime reads 100. Then write MTIMECMP_HI=1 -> timer_irq=0 on the next cycle.
- MTIME_LO=32'h0000_80F0: lb @+0x08 -> 32'hFFFF_FFF0; lbu @+0x08 -> 32'h0000_00F0; lh @+0x08 -> 32'hFFFF_80F0. lw @BASE+0x100 -> hit=0, rd=0; sw there leaves all state unchanged.
